// File: rtl/serial_nibble_deserializer.sv
// serial_nibble_deserializer: assembles serial bits into WIDTH-bit words with optional even parity
// and a one-entry valid/ready output buffer.
module serial_nibble_deserializer #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, pos;
  logic [WIDTH-1:0] sreg, sreg_n, cap, word;
  logic done, perr;
  assign busy = state != IDLE;
  assign pos = MSB_FIRST ? CW'(WIDTH - 1) - cnt : cnt;
  // Each bit position is written exactly once per word, so OR-ing the new bit in is enough.
  assign cap = (state == IDLE ? '0 : sreg) | ({{(WIDTH-1){1'b0}}, sin} << pos);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sreg_n = sreg;
    done = 1'b0;
    word = cap;
    perr = 1'b0;
    if (sin_valid)
      case (state)
        IDLE: begin
          sreg_n = cap;
          cnt_n = CW'(1);
          state_n = SHIFT;
        end
        SHIFT: begin
          sreg_n = cap;
          cnt_n = cnt == CW'(WIDTH - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state_n = PARITY_EN ? PARITY : IDLE;
            done = !PARITY_EN;
          end
        end
        PARITY: begin
          done = 1'b1;
          word = sreg;
          perr = ^sreg ^ sin;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sreg <= sreg_n;
    end
  // A completing word may replace the buffered one only if that one is leaving this edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
    end else if (clr) begin
      dout <= '0;
      dout_valid <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
    end else if (done && dout_valid && !dout_ready)
      overrun <= 1'b1;
    else if (done) begin
      dout <= word;
      par_err <= perr;
      dout_valid <= 1'b1;
    end else if (dout_ready)
      dout_valid <= 1'b0;
endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// tb_serial_nibble_deserializer: directed stimulus with a scoreboard queue checked on every transfer.
module tb_serial_nibble_deserializer;
  logic clk = 0, rst = 1, clr = 0;
  logic sin = 0, sin_valid = 0, dout_ready = 0;
  logic [3:0] dout;
  logic dout_valid, par_err, overrun, busy;
  logic sin1 = 0, sin_valid1 = 0, dout_ready1 = 0;
  logic [3:0] dout1;
  logic dout_valid1, par_err1, overrun1, busy1;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] d; logic p;} exp_t;
  exp_t q[$], q1[$];

  always #5 clk = ~clk;

  serial_nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .par_err(par_err), .overrun(overrun), .busy(busy));
  serial_nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin1), .sin_valid(sin_valid1), .dout(dout1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready1), .par_err(par_err1), .overrun(overrun1), .busy(busy1));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every negedge with valid&ready precedes exactly one transfer edge.
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid && dout_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 transfer: got word %b with nothing expected", dout);
      end else begin
        e = q.pop_front();
        chk("u0 dout", 16'(dout), 16'(e.d));
        chk("u0 par_err", 16'(par_err), 16'(e.p));
      end
    end
    if (dout_valid1 && dout_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 transfer: got word %b with nothing expected", dout1);
      end else begin
        e = q1.pop_front();
        chk("u1 dout", 16'(dout1), 16'(e.d));
        chk("u1 par_err", 16'(par_err1), 16'(e.p));
      end
    end
  end

  task automatic send(input logic b);
    sin = b; sin_valid = 1;
    @(posedge clk); #1;
    sin_valid = 0;
  endtask

  task automatic send1(input logic b);
    sin1 = b; sin_valid1 = 1;
    @(posedge clk); #1;
    sin_valid1 = 0;
  endtask

  task automatic send_word(input logic [3:0] d, input logic p);
    for (int i = 0; i < 4; i++) send(d[i]);
    send(p);
  endtask

  task automatic drain();
    dout_ready = 1;
    @(posedge clk); #1;
    dout_ready = 0;
  endtask

  initial begin
    #12;
    chk("reset dout", 16'(dout), 0);
    chk("reset valid", 16'(dout_valid), 0);
    chk("reset par_err", 16'(par_err), 0);
    chk("reset overrun", 16'(overrun), 0);
    chk("reset busy", 16'(busy), 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    // basic word
    send(1); send(0); send(1);
    chk("basic busy shift", 16'(busy), 1);
    send(0);
    chk("basic busy parity", 16'(busy), 1);
    chk("basic not yet valid", 16'(dout_valid), 0);
    q.push_back('{4'b0101, 1'b0});
    send(0);
    chk("basic valid", 16'(dout_valid), 1);
    chk("basic dout", 16'(dout), 16'b0101);
    chk("basic par_err", 16'(par_err), 0);
    chk("basic busy idle", 16'(busy), 0);
    drain();
    chk("basic drained", 16'(dout_valid), 0);
    // parity error with gaps
    for (int i = 0; i < 4; i++) begin
      send(1);
      repeat (3) @(posedge clk);
      #1;
      chk("gap busy", 16'(busy), 1);
      chk("gap no valid", 16'(dout_valid), 0);
    end
    q.push_back('{4'b1111, 1'b1});
    send(1);
    chk("perr dout", 16'(dout), 16'b1111);
    chk("perr par_err", 16'(par_err), 1);
    drain();
    // overrun
    q.push_back('{4'b0101, 1'b0});
    send_word(4'b0101, 0);
    send_word(4'b0011, 0);
    chk("ovr dout held", 16'(dout), 16'b0101);
    chk("ovr flag", 16'(overrun), 1);
    chk("ovr valid", 16'(dout_valid), 1);
    drain();
    chk("ovr drained", 16'(dout_valid), 0);
    chk("ovr sticky", 16'(overrun), 1);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    chk("clr overrun", 16'(overrun), 0);
    chk("clr dout", 16'(dout), 0);
    // simultaneous drain and load
    q.push_back('{4'b0101, 1'b0});
    send_word(4'b0101, 0);
    q.push_back('{4'b1100, 1'b0});
    send(0); send(0); send(1); send(1);
    sin = 0; sin_valid = 1; dout_ready = 1;
    @(posedge clk); #1;
    sin_valid = 0; dout_ready = 0;
    chk("simul dout", 16'(dout), 16'b1100);
    chk("simul valid", 16'(dout_valid), 1);
    chk("simul overrun", 16'(overrun), 0);
    drain();
    // asynchronous reset mid-word
    send(1); send(0);
    chk("pre-rst busy", 16'(busy), 1);
    #3 rst = 1;
    #1;
    chk("rst dout", 16'(dout), 0);
    chk("rst valid", 16'(dout_valid), 0);
    chk("rst busy", 16'(busy), 0);
    chk("rst overrun", 16'(overrun), 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    q.push_back('{4'b1001, 1'b0});
    send_word(4'b1001, 0);
    chk("post-rst dout", 16'(dout), 16'b1001);
    chk("post-rst par_err", 16'(par_err), 0);
    drain();
    // MSB_FIRST=1, no parity
    q1.push_back('{4'b1000, 1'b0});
    send1(1); send1(0); send1(0);
    chk("msb not yet valid", 16'(dout_valid1), 0);
    send1(0);
    chk("msb dout", 16'(dout1), 16'b1000);
    chk("msb valid", 16'(dout_valid1), 1);
    chk("msb par_err", 16'(par_err1), 0);
    chk("msb busy", 16'(busy1), 0);
    dout_ready1 = 1;
    @(posedge clk); #1;
    dout_ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("u0 queue empty", 16'(q.size()), 0);
    chk("u1 queue empty", 16'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_nibble_deserializer.md
Name: serial_nibble_deserializer

Overview:
- Converts a serial bit stream into WIDTH-bit parallel words, with an optional even-parity check per word.
- Sits directly upstream of the 4-bit holding register and drives that register's d input from dout.
- Holds each completed word in a one-entry output buffer with a valid/ready handshake.
- Assembly of the next word continues while the buffer is occupied.

Parameters:
- WIDTH, 4, data bits per word; legal range 2..16.
- MSB_FIRST, 0: first serial bit lands in dout[0]. 1: first serial bit lands in dout[WIDTH-1].
- PARITY_EN, 1: one even-parity bit follows each word. 0: no parity bit; par_err is tied 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- clr  input  1  synchronous clear; same effect as rst, applied at the clock edge
- sin  input  1  serial data bit
- sin_valid  input  1  sin is sampled at a clock edge only when this is 1
- dout  output  WIDTH  assembled word; stable while dout_valid=1
- dout_valid  output  1  output buffer holds a word
- dout_ready  input  1  consumer accepts the word
- par_err  output  1  parity result for the word in dout; meaningful only while dout_valid=1
- overrun  output  1  sticky; a completed word was dropped because the buffer was full
- busy  output  1  a word is partially assembled (state is not IDLE)

Behaviour:
- Reset (rst, asynchronous) and clr (synchronous) have the same effect:
  - state goes to IDLE; bit counter and shift register go to 0;
  - dout=0, dout_valid=0, par_err=0, overrun=0, busy=0;
  - any partially assembled word is discarded.
- clr has priority over every other input in the same cycle.
- Assembly FSM, with states IDLE, SHIFT and PARITY. It advances only on edges where sin_valid=1. Cycles with sin_valid=0 freeze it, and there is no timeout.
  - IDLE: a valid bit is captured and the counter is set to 1. The FSM moves to SHIFT.
  - SHIFT: each valid bit is captured and the counter is incremented.
    - When the counter reaches WIDTH, the data is complete.
    - The FSM then moves to PARITY if PARITY_EN=1; otherwise the word is complete and the FSM returns to IDLE.
  - PARITY: the valid bit is the parity bit. The word is complete, with perr = XOR of the WIDTH data bits and the parity bit. The FSM returns to IDLE.
- Bit placement:
  - MSB_FIRST=0: the k-th data bit (k=0..WIDTH-1) goes to bit k.
  - MSB_FIRST=1: the k-th data bit goes to bit WIDTH-1-k.
- Output buffer behaviour on word completion at edge N:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 at edge N: dout, par_err and dout_valid=1 are loaded, visible after edge N. Latency from the final serial bit to dout_valid is 1 edge.
  - If dout_valid=1 and dout_ready=0: the word is dropped and overrun is set to 1. dout and par_err are unchanged.
- Handshake:
  - A transfer occurs at any edge where dout_valid=1 and dout_ready=1.
  - If no new word completes at that edge, dout_valid goes to 0 after the edge. dout keeps its last value.
  - dout_ready has no effect while dout_valid=0.
- Simultaneous drain and completion at the same edge: the new word is loaded, dout_valid stays 1, and there is no overrun and no bubble.
- overrun clears only on rst or clr.
- busy=1 in SHIFT and PARITY.
- Back-to-back words need no gap: the first bit of the next word may arrive on the edge immediately after completion.
- The counter wraps to 0 on completion; no other wrap-around exists.

Test Plan:
All cases use WIDTH=4, PARITY_EN=1 and MSB_FIRST=0 unless stated.
- Basic word:
  - Stimulus: dout_ready=0; sin bits 1,0,1,0, then parity 0, on consecutive valid cycles.
  - Response: after the 5th edge, dout=4'b0101, dout_valid=1, par_err=0, busy=0.
- Parity error and gaps:
  - Stimulus: bits 1,1,1,1, then parity 1, with sin_valid=0 gaps of 3 cycles between bits.
  - Response: dout=4'b1111, par_err=1; the FSM does not advance during the gaps.
- Overrun:
  - Stimulus: dout_ready held 0; send word 0101/p0, then word 0011/p0.
  - Response: dout stays 4'b0101 and overrun=1.
  - Follow-up: after a dout_ready pulse, dout_valid=0 while overrun stays 1 until clr.
- Simultaneous drain and load:
  - Stimulus: word 0101 held; dout_ready=1 on the same edge as the parity bit of word 1100/p0.
  - Response: the next cycle shows dout=4'b1100, dout_valid=1, overrun=0.
- Reset mid-word:
  - Stimulus: after 2 bits, assert rst asynchronously mid-cycle.
  - Response: all outputs are 0 immediately.
  - Follow-up: after release, sending 1,0,0,1/p0 gives dout=4'b1001, par_err=0.
- MSB_FIRST=1, PARITY_EN=0:
  - Stimulus: bits 1,0,0,0.
  - Response: after the 4th edge, dout=4'b1000 and par_err=0.
